// File: rtl/rvvi_trace_pkg.sv
// rtl/rvvi_trace_pkg.sv - RVVI retire record layout and sizing helpers
package rvvi_trace_pkg;

    // Record, MSB to LSB: {order, pc_rdata, pc_wdata, insn, isize[2:0], trap, halt, mode[1:0], x_wb[31:0], x_wdata}
    function automatic int rec_w(input int ilen, input int xlen);
        return 4 * xlen + ilen + 39;
    endfunction

    localparam int X_WDATA_LSB = 0;

    function automatic int x_wb_lsb(input int xlen);
        return xlen;
    endfunction

    function automatic int mode_lsb(input int xlen);
        return xlen + 32;
    endfunction

    function automatic int halt_lsb(input int xlen);
        return xlen + 34;
    endfunction

    function automatic int trap_lsb(input int xlen);
        return xlen + 35;
    endfunction

    function automatic int isize_lsb(input int xlen);
        return xlen + 36;
    endfunction

    function automatic int insn_lsb(input int xlen);
        return xlen + 39;
    endfunction

    function automatic int pc_wdata_lsb(input int ilen, input int xlen);
        return xlen + 39 + ilen;
    endfunction

    function automatic int pc_rdata_lsb(input int ilen, input int xlen);
        return 2 * xlen + 39 + ilen;
    endfunction

    function automatic int order_lsb(input int ilen, input int xlen);
        return 3 * xlen + 39 + ilen;
    endfunction

    function automatic int hart_w(input int nhart);
        return (nhart > 1) ? $clog2(nhart) : 1;
    endfunction

endpackage

// File: rtl/rvvi_retire_hart_fifo.sv
// rtl/rvvi_retire_hart_fifo.sv - one hart's NRET-write, single-read FIFO with order-gap tracker
module rvvi_retire_hart_fifo
    import rvvi_trace_pkg::*;
#(
    parameter int ILEN  = 32,
    parameter int XLEN  = 32,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clr_err,
    input  logic [NRET-1:0]                      ret_valid,
    input  logic [NRET*rec_w(ILEN, XLEN)-1:0]    ret_rec,
    input  logic                                 pop,
    output logic [$clog2(DEPTH+1)-1:0]           count,
    output logic [rec_w(ILEN, XLEN)-1:0]         head,
    output logic                                 ovf,
    output logic                                 order_err
);

    localparam int REC_W     = rec_w(ILEN, XLEN);
    localparam int ORDER_LSB = order_lsb(ILEN, XLEN);
    localparam int PW        = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH + 1);

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_synced;
    logic [XLEN-1:0]  r_expected;
    logic             r_ovf;
    logic             r_order_err;

    logic [CW-1:0]    w_k;
    logic [CW-1:0]    w_free;
    logic             w_accept;
    logic             w_drop;
    logic [PW-1:0]    w_slot_idx [NRET];
    logic             w_synced_n;
    logic [XLEN-1:0]  w_expected_n;
    logic [XLEN-1:0]  w_order;
    logic             w_gap;

    // Valid slots are packed densely in ascending slot order.
    always_comb begin
        w_k = '0;
        for (int s = 0; s < NRET; s++) begin
            w_slot_idx[s] = w_k[PW-1:0];
            if (ret_valid[s]) begin
                w_k = w_k + CW'(1);
            end
        end
    end

    // Free space is taken from the start of the cycle; a same-cycle pop gives no credit.
    assign w_free   = CW'(DEPTH) - r_count;
    assign w_accept = (w_k != '0) && (w_free >= w_k);
    assign w_drop   = (w_k != '0) && !w_accept;

    // Every accepted record sets expected to order+1; a clear makes this cycle's first record resync.
    always_comb begin
        w_synced_n   = r_synced && !clr_err;
        w_expected_n = r_expected;
        w_gap        = 1'b0;
        w_order      = '0;
        if (w_accept) begin
            for (int s = 0; s < NRET; s++) begin
                if (ret_valid[s]) begin
                    w_order = ret_rec[s*REC_W + ORDER_LSB +: XLEN];
                    if (w_synced_n && (w_order != w_expected_n)) begin
                        w_gap = 1'b1;
                    end
                    w_expected_n = w_order + XLEN'(1);
                    w_synced_n   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_synced    <= 1'b0;
            r_expected  <= '0;
            r_ovf       <= 1'b0;
            r_order_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + w_k[PW-1:0];
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count     <= r_count + (w_accept ? w_k : '0) - CW'(pop);
            r_synced    <= w_synced_n;
            r_expected  <= w_expected_n;
            r_ovf       <= !clr_err && (r_ovf || w_drop);
            r_order_err <= !clr_err && (r_order_err || w_gap);
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int s = 0; s < NRET; s++) begin
                if (ret_valid[s]) begin
                    r_mem[r_wr_ptr + w_slot_idx[s]] <= ret_rec[s*REC_W +: REC_W];
                end
            end
        end
    end

    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];
    assign ovf       = r_ovf;
    assign order_err = r_order_err;

endmodule

// File: rtl/rvvi_retire_buffer.sv
// rtl/rvvi_retire_buffer.sv - per-hart retire FIFOs drained round-robin to one trace consumer
module rvvi_retire_buffer
    import rvvi_trace_pkg::*;
#(
    parameter int ILEN  = 32,
    parameter int XLEN  = 32,
    parameter int NHART = 2,
    parameter int NRET  = 2,
    parameter int DEPTH = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [NHART*NRET-1:0]                     ret_valid,
    input  logic [NHART*NRET*rec_w(ILEN, XLEN)-1:0]   ret_rec,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [hart_w(NHART)-1:0]                  out_hart,
    output logic [rec_w(ILEN, XLEN)-1:0]              out_rec,
    output logic [NHART-1:0]                          ovf,
    output logic [NHART-1:0]                          order_err,
    input  logic                                      clr_err
);

    localparam int REC_W = rec_w(ILEN, XLEN);
    localparam int HW    = hart_w(NHART);
    localparam int CW    = $clog2(DEPTH + 1);

    logic [CW-1:0]    w_count [NHART];
    logic [REC_W-1:0] w_head  [NHART];
    logic [NHART-1:0] w_elig;
    logic [NHART-1:0] w_pop;
    logic [HW-1:0]    w_lo;
    logic [HW-1:0]    w_hi;
    logic             w_hi_found;
    logic [HW-1:0]    w_arb;
    logic [HW-1:0]    w_sel;
    logic [HW-1:0]    r_rr;
    logic [HW-1:0]    r_hold_hart;
    logic             r_hold;

    for (genvar h = 0; h < NHART; h++) begin : g_hart
        rvvi_retire_hart_fifo #(
            .ILEN  (ILEN),
            .XLEN  (XLEN),
            .NRET  (NRET),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .clr_err   (clr_err),
            .ret_valid (ret_valid[h*NRET +: NRET]),
            .ret_rec   (ret_rec[h*NRET*REC_W +: NRET*REC_W]),
            .pop       (w_pop[h]),
            .count     (w_count[h]),
            .head      (w_head[h]),
            .ovf       (ovf[h]),
            .order_err (order_err[h])
        );
        assign w_elig[h] = (w_count[h] != '0);
        assign w_pop[h]  = out_valid && out_ready && (w_sel == HW'(h));
    end

    // First eligible hart at/after the RR pointer, else the lowest eligible (wrap-around).
    always_comb begin
        w_lo       = '0;
        w_hi       = '0;
        w_hi_found = 1'b0;
        for (int i = NHART - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_lo = HW'(i);
                if (HW'(i) >= r_rr) begin
                    w_hi       = HW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_arb = w_hi_found ? w_hi : w_lo;
    end

    // A stalled offer keeps its hart; that head cannot move until it is popped.
    assign w_sel     = r_hold ? r_hold_hart : w_arb;
    assign out_valid = |w_elig;
    assign out_hart  = w_sel;
    assign out_rec   = out_valid ? w_head[w_sel] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr        <= '0;
            r_hold      <= 1'b0;
            r_hold_hart <= '0;
        end else begin
            r_hold      <= out_valid && !out_ready;
            r_hold_hart <= w_sel;
            if (out_valid && out_ready) begin
                r_rr <= (w_sel == HW'(NHART - 1)) ? '0 : w_sel + HW'(1);
            end
        end
    end

endmodule

// File: tb/tb_rvvi_retire_buffer.sv
// tb/tb_rvvi_retire_buffer.sv - directed scoreboard bench for rvvi_retire_buffer
module tb_rvvi_retire_buffer;

    localparam int ILEN      = 32;
    localparam int XLEN      = 32;
    localparam int NHART     = 2;
    localparam int NRET      = 2;
    localparam int DEPTH     = 8;
    localparam int REC_W     = 4 * XLEN + ILEN + 39;
    localparam int ORDER_LSB = REC_W - XLEN;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NHART*NRET-1:0]         ret_valid;
    logic [NHART*NRET*REC_W-1:0]   ret_rec;
    logic                          out_valid;
    logic                          out_ready;
    logic [0:0]                    out_hart;
    logic [REC_W-1:0]              out_rec;
    logic [NHART-1:0]              ovf;
    logic [NHART-1:0]              order_err;
    logic                          clr_err;

    rvvi_retire_buffer #(
        .ILEN  (ILEN),
        .XLEN  (XLEN),
        .NHART (NHART),
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ret_valid (ret_valid),
        .ret_rec   (ret_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_hart  (out_hart),
        .out_rec   (out_rec),
        .ovf       (ovf),
        .order_err (order_err),
        .clr_err   (clr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int pops  = 0;
    int p0;
    int cnt [NHART];
    logic [REC_W-1:0] sb0 [$];
    logic [REC_W-1:0] sb1 [$];
    logic [REC_W-1:0] held;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input logic [31:0] ord);
        logic [223:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        t[ORDER_LSB +: 32] = ord;
        return t[REC_W-1:0];
    endfunction

    task automatic put(input int h, input int s, input logic [31:0] ord);
        ret_valid[h*NRET+s] = 1'b1;
        ret_rec[(h*NRET+s)*REC_W +: REC_W] = mk_rec(ord);
    endtask

    task automatic idle();
        ret_valid = '0;
    endtask

    // Models the coming edge: atomic push against start-of-cycle space, then the pop.
    task automatic tick();
        logic [REC_W-1:0] e;
        #1;
        for (int h = 0; h < NHART; h++) begin
            int k;
            k = 0;
            for (int s = 0; s < NRET; s++) if (ret_valid[h*NRET+s]) k++;
            if (k > 0 && DEPTH - cnt[h] >= k) begin
                for (int s = 0; s < NRET; s++) begin
                    if (ret_valid[h*NRET+s]) begin
                        if (h == 0) sb0.push_back(ret_rec[(h*NRET+s)*REC_W +: REC_W]);
                        else        sb1.push_back(ret_rec[(h*NRET+s)*REC_W +: REC_W]);
                    end
                end
                cnt[h] += k;
            end
        end
        if (out_valid && out_ready) begin
            if (out_hart == 1'b0) begin
                chk("sb0_nonempty", sb0.size() > 0, 1);
                if (sb0.size() > 0) begin
                    e = sb0.pop_front();
                    chk("pop_rec_h0", out_rec, e);
                end
            end else begin
                chk("sb1_nonempty", sb1.size() > 0, 1);
                if (sb1.size() > 0) begin
                    e = sb1.pop_front();
                    chk("pop_rec_h1", out_rec, e);
                end
            end
            cnt[out_hart]--;
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && out_valid; i++) tick();
        chk({tag, "_empty"}, out_valid, 0);
    endtask

    task automatic clear_pulse();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, summary required");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ret_valid = '0;
        ret_rec = '0;
        out_ready = 1'b0;
        clr_err = 1'b0;
        cnt[0] = 0;
        cnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_hart", out_hart, 0);
        chk("rst_rec", out_rec, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_order_err", order_err, 0);
        rst_n = 1'b1;
        tick();

        // Basic two-slot push, one-cycle latency
        put(0, 0, 10); put(0, 1, 11);
        tick(); idle();
        chk("t1_valid", out_valid, 1);
        chk("t1_hart", out_hart, 0);
        chk("t1_order10", out_rec[ORDER_LSB +: 32], 10);
        out_ready = 1'b1;
        tick();
        chk("t1_order11", out_rec[ORDER_LSB +: 32], 11);
        tick();
        out_ready = 1'b0;
        chk("t1_empty", out_valid, 0);
        chk("t1_order_err", order_err, 0);

        // Hold while stalled, then round-robin
        put(0, 0, 12); put(0, 1, 13);
        tick(); idle();
        held = out_rec;
        put(1, 0, 50); put(1, 1, 51);
        tick(); idle();
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_hart", out_hart, 0);
            chk("t2_hold_rec", out_rec, held);
            tick();
        end
        out_ready = 1'b1;
        chk("t2_g0", out_hart, 0); tick();
        chk("t2_g1", out_hart, 1); tick();
        chk("t2_g2", out_hart, 0); tick();
        chk("t2_g3", out_hart, 1); tick();
        out_ready = 1'b0;
        chk("t2_empty", out_valid, 0);

        // Fill hart1 to 7, atomic drop, gap after drop, full+push+pop
        for (int i = 0; i < 3; i++) begin
            put(1, 0, 52 + 2 * i); put(1, 1, 53 + 2 * i);
            tick(); idle();
        end
        put(1, 0, 58);
        tick(); idle();
        put(1, 0, 59); put(1, 1, 60);
        tick(); idle();
        chk("t3_ovf", ovf, 2'b10);
        chk("t3_no_err_yet", order_err, 0);
        put(1, 0, 61);
        tick(); idle();
        chk("t3_gap_after_drop", order_err, 2'b10);
        p0 = pops;
        out_ready = 1'b1;
        put(1, 1, 62);
        tick(); idle();
        drain("t3");
        chk("t3_drained", pops - p0, 8);
        clear_pulse();
        chk("t3_clr_ovf", ovf, 0);
        chk("t3_clr_err", order_err, 0);

        // Order gap, stickiness, clear and resync
        put(0, 0, 5); put(0, 1, 7);
        tick(); idle();
        chk("t4_gap", order_err, 2'b01);
        put(0, 0, 8);
        tick(); idle();
        chk("t4_after8", order_err, 2'b01);
        clear_pulse();
        chk("t4_clr_err", order_err, 0);
        chk("t4_clr_ovf", ovf, 0);
        put(0, 0, 100);
        tick(); idle();
        chk("t4_resync", order_err, 0);

        // Order wrap on hart1
        put(1, 0, 32'hFFFF_FFFE); put(1, 1, 32'hFFFF_FFFF);
        tick(); idle();
        put(1, 0, 32'h0000_0000); put(1, 1, 32'h0000_0001);
        tick(); idle();
        chk("t5_wrap", order_err, 0);
        drain("t5");

        // Asynchronous reset with records buffered
        out_ready = 1'b0;
        put(0, 0, 300); put(0, 1, 301); put(1, 0, 2); put(1, 1, 3);
        tick(); idle();
        chk("t6_valid", out_valid, 1);
        chk("t6_err_before", order_err, 2'b01);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", out_valid, 0);
        sb0.delete();
        sb1.delete();
        cnt[0] = 0;
        cnt[1] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        chk("t6_post_valid", out_valid, 0);
        chk("t6_post_ovf", ovf, 0);
        chk("t6_post_err", order_err, 0);
        put(1, 0, 9);
        tick(); idle();
        p0 = pops;
        drain("t6");
        chk("t6_one_record", pops - p0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rvvi_retire_buffer.md
Name: rvvi_retire_buffer

Overview:
- Multi-hart, multi-retire capture buffer for the RVVI trace path.
- Accepts up to NRET retired-instruction records per hart per cycle and stores them in a per-hart FIFO of depth DEPTH.
- Drains one record per cycle to a single ready/valid trace consumer, with round-robin arbitration across harts.
- Checks that each hart's order stream is gap-free and flags overflow; sits between RTL retirement ports and the trace/compare agent.

Parameters:
- ILEN, 32, instruction width
- XLEN, 32, register/PC/order width
- NHART, 2, number of harts
- NRET, 2, retire slots per hart per cycle
- DEPTH, 8, entries per hart FIFO; power of 2, DEPTH >= 2*NRET
- REC_W, 4*XLEN+ILEN+39 (derived, not overridable), packed record width

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ret_valid  in  NHART*NRET  slot valid, index h*NRET+s
- ret_rec  in  NHART*NRET*REC_W  packed record per slot, fields {order, pc_rdata, pc_wdata, insn, isize[2:0], trap, halt, mode[1:0], x_wb[31:0], x_wdata}
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts
- out_hart  out  max(1,$clog2(NHART))  source hart of out_rec
- out_rec  out  REC_W  head record of selected hart
- ovf  out  NHART  sticky overflow flag per hart
- order_err  out  NHART  sticky order-gap flag per hart
- clr_err  in  1  synchronous clear of ovf/order_err and order resync

Behaviour:
- Reset (async, rst_n=0): all FIFO counts and pointers 0; out_valid=0, out_hart=0, out_rec=0; ovf=0, order_err=0; RR pointer=hart 0; each hart's order tracker marked unsynced.
- Push, per hart per cycle: valid slots are taken in ascending slot index, k = popcount. If free = DEPTH - count (start-of-cycle value; a same-cycle pop gives no credit) is >= k, all k records are written in slot order. Otherwise none are written (atomic drop) and ovf[h] is set.
- Pointers wrap modulo DEPTH. count is updated as count + pushed - popped.
- Order check, on each written record in slot order: if unsynced, expected = order+1 and state becomes synced. Else if order != expected, set order_err[h] and expected = order+1 (resync). Else expected += 1, wrapping modulo 2^XLEN (all-ones followed by 0 is legal).
- Dropped records do not update expected, so the next accepted record flags order_err.
- Output: a hart is eligible when count != 0. When not holding, the arbiter selects the first eligible hart at or after the RR pointer; out_valid = any eligible.
- out_rec/out_hart are the head of the selected hart, driven combinationally from FIFO storage and registered state.
- Hold rule: once out_valid=1 and out_ready=0, out_hart and out_rec stay stable until accepted.
- On out_valid&&out_ready the head is popped and the RR pointer becomes out_hart+1 (mod NHART).
- Latency: a record written at edge N appears on out_rec in cycle N+1 at the earliest.
- Full FIFO plus same-cycle push and pop: the push is evaluated against start-of-cycle free space and the pop still occurs.
- clr_err=1: clears ovf and order_err, sets every tracker unsynced; FIFO contents are kept. A push in the same cycle is accepted and re-syncs; an error raised in the same cycle as the clear is lost (clear wins).
- Reset asserted mid-operation discards all buffered records immediately.

Decomposition:
- Package rvvi_trace_pkg holds: a function rec_w(ILEN,XLEN); field offset localparams/functions (ORDER_LSB, PC_RDATA_LSB, ... computed from XLEN/ILEN); and the function hart_w(NHART).
- Sub-module rvvi_retire_hart_fifo: a single hart's multi-write (NRET), single-read FIFO plus order tracker. It exposes count, head, pop, ovf, order_err. It is instantiated NHART times by generate.
- The top level holds only the RR arbiter, hold register and output mux.

Test Plan:
- Reset then hart0 slots 0,1 valid, orders 10,11 -> next cycle out_valid=1, out_hart=0, out_rec.order=10; with out_ready=1 next order=11; order_err=0.
- out_ready=0 for 5 cycles with hart0 and hart1 both non-empty -> out_hart/out_rec stable; on release, hart1 is granted next (RR).
- Fill hart1 to 7/8, then push 2 slots with out_ready=0 -> nothing written, ovf[1]=1, count stays 7. A later push of order expected+2 -> order_err[1]=1.
- Order stream 5,7 on hart0 -> order_err[0]=1 after the 7; then 8 gives no new error. clr_err pulse -> flags 0; the next order 100 is accepted silently.
- Order wrap: 0xFFFFFFFF then 0x00000000 -> order_err=0.
- rst_n low while 4 records are buffered -> out_valid=0 asynchronously; after release all counts are 0 and flags are 0.
